// File: rtl/dbg_pkg.sv
// Shared definitions for the serial debug unit (hex parser and hex printer).
// Holds the transmit FSM state encoding, the TX request type codes and the
// ASCII control characters that both directions of the debug link rely on.
package dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHAR = 3'd1,
        S_CR   = 3'd2,
        S_LF   = 3'd3,
        S_DONE = 3'd4
    } tx_state_t;

    localparam logic [1:0] T_RAW  = 2'b00;
    localparam logic [1:0] T_HEXB = 2'b01;
    localparam logic [1:0] T_HEXW = 2'b10;
    localparam logic [1:0] T_CRLF = 2'b11;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;

endpackage

// File: rtl/nib2ascii.sv
// Converts one nibble to its uppercase ASCII hex digit.
// Latency: combinational.
// Ports: nib (4-bit value), asc (8-bit character '0'-'9', 'A'-'F').
module nib2ascii (
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    assign asc = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                               : (8'h37 + {4'h0, nib});

endmodule

// File: rtl/hex_print.sv
// Formats a raw byte, a hex byte, a hex word or a bare line end as an ASCII
// character frame for the UART transmitter; req/ack on the control side.
// Latency: first char the cycle after req is sampled; one char per clock
// while rdy_tx is high; ack_tx pulses one cycle after the last char.
// Backpressure: vld_tx/d_tx and all internal state hold while !rdy_tx.
// Ports: clk, rstn; req_tx/type_tx/dat_tx/busy_tx/ack_tx (control side);
//        d_tx/vld_tx/rdy_tx (UART side).
module hex_print
    import dbg_pkg::*;
#(
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_tx,
    input  logic [1:0]  type_tx,
    input  logic [31:0] dat_tx,
    output logic        busy_tx,
    output logic        ack_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);

    tx_state_t   state, state_nxt;
    logic [31:0] sh, sh_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  type_q, type_nxt;
    logic [7:0]  d_nxt;
    logic [7:0]  asc_nxt;
    logic        xfer;

    // The digit is looked up on the value the shift register is about to
    // take, so d_tx can be a plain flop and still be correct in the first
    // CHAR cycle and right after each shift.
    nib2ascii u_nib2ascii (
        .nib (sh_nxt[31:28]),
        .asc (asc_nxt)
    );

    assign xfer = vld_tx && rdy_tx;

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        type_nxt  = type_q;
        case (state)
            S_IDLE: begin
                if (req_tx) begin
                    type_nxt  = type_tx;
                    state_nxt = S_CHAR;
                    case (type_tx)
                        T_RAW: begin
                            sh_nxt  = {dat_tx[7:0], 24'h0};
                            cnt_nxt = 4'd1;
                        end
                        T_HEXB: begin
                            sh_nxt  = {dat_tx[7:0], 24'h0};
                            cnt_nxt = 4'd2;
                        end
                        T_HEXW: begin
                            sh_nxt  = dat_tx;
                            cnt_nxt = 4'd8;
                        end
                        default: begin
                            sh_nxt    = dat_tx;
                            cnt_nxt   = 4'd0;
                            state_nxt = S_CR;
                        end
                    endcase
                end
            end
            S_CHAR: begin
                if (xfer) begin
                    if (cnt > 4'd1) begin
                        sh_nxt  = {sh[27:0], 4'h0};
                        cnt_nxt = cnt - 4'd1;
                    end else if (APPEND_CRLF && (type_q == T_HEXB || type_q == T_HEXW)) begin
                        state_nxt = S_CR;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_CR:    if (xfer) state_nxt = S_LF;
            S_LF:    if (xfer) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        d_nxt = 8'h00;
        case (state_nxt)
            S_CHAR:  d_nxt = (type_nxt == T_RAW) ? sh_nxt[31:24] : asc_nxt;
            S_CR:    d_nxt = CH_CR;
            S_LF:    d_nxt = CH_LF;
            default: d_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            sh      <= 32'h0;
            cnt     <= 4'd0;
            type_q  <= T_RAW;
            busy_tx <= 1'b0;
            ack_tx  <= 1'b0;
            vld_tx  <= 1'b0;
            d_tx    <= 8'h00;
        end else begin
            state   <= state_nxt;
            sh      <= sh_nxt;
            cnt     <= cnt_nxt;
            type_q  <= type_nxt;
            busy_tx <= (state_nxt != S_IDLE);
            ack_tx  <= (state_nxt == S_DONE);
            vld_tx  <= (state_nxt == S_CHAR) || (state_nxt == S_CR) || (state_nxt == S_LF);
            d_tx    <= d_nxt;
        end
    end

endmodule

// File: tb/tb_hex_print.sv
module tb_hex_print;
    import dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req1 = 1'b0, req0 = 1'b0;
    logic [1:0]  type_tx = 2'b00;
    logic [31:0] dat_tx = 32'h0;
    logic        rdy = 1'b1;
    logic        busy1, ack1, vld1, busy0, ack0, vld0;
    logic [7:0]  d1, d0;

    int nchk = 0;
    int nerr = 0;
    int ack_cnt1 = 0;
    int ack_cnt0 = 0;
    logic [7:0] q1[$];
    logic [7:0] q0[$];

    always #5 clk = ~clk;

    hex_print #(.APPEND_CRLF(1'b1)) u_dut1 (
        .clk(clk), .rstn(rstn), .req_tx(req1), .type_tx(type_tx), .dat_tx(dat_tx),
        .busy_tx(busy1), .ack_tx(ack1), .d_tx(d1), .vld_tx(vld1), .rdy_tx(rdy)
    );

    hex_print #(.APPEND_CRLF(1'b0)) u_dut0 (
        .clk(clk), .rstn(rstn), .req_tx(req0), .type_tx(type_tx), .dat_tx(dat_tx),
        .busy_tx(busy0), .ack_tx(ack0), .d_tx(d0), .vld_tx(vld0), .rdy_tx(rdy)
    );

    // Scoreboard: every accepted char is popped and compared.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rstn && vld1 && rdy) begin
            nchk++;
            if (q1.size() == 0) begin
                nerr++;
                $display("FAIL char_crlf1: got d_tx=%h, expected no char", d1);
            end else begin
                e = q1.pop_front();
                if (d1 !== e) begin
                    nerr++;
                    $display("FAIL char_crlf1: got d_tx=%h, expected %h", d1, e);
                end
            end
        end
        if (ack1 === 1'b1) ack_cnt1++;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rstn && vld0 && rdy) begin
            nchk++;
            if (q0.size() == 0) begin
                nerr++;
                $display("FAIL char_crlf0: got d_tx=%h, expected no char", d0);
            end else begin
                e = q0.pop_front();
                if (d0 !== e) begin
                    nerr++;
                    $display("FAIL char_crlf0: got d_tx=%h, expected %h", d0, e);
                end
            end
        end
        if (ack0 === 1'b1) ack_cnt0++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input bit inst, input logic [7:0] b);
        if (inst) q1.push_back(b);
        else      q0.push_back(b);
    endtask

    task automatic push_frame(input bit inst, input logic [1:0] t, input logic [31:0] d, input bit crlf);
        string hexs = "0123456789ABCDEF";
        case (t)
            2'b00: push_b(inst, d[7:0]);
            2'b01: begin
                push_b(inst, hexs[int'(d[7:4])]);
                push_b(inst, hexs[int'(d[3:0])]);
            end
            2'b10: for (int i = 7; i >= 0; i--) push_b(inst, hexs[int'(d[i*4 +: 4])]);
            default: begin
                push_b(inst, 8'h0D);
                push_b(inst, 8'h0A);
            end
        endcase
        if (crlf && (t == 2'b01 || t == 2'b10)) begin
            push_b(inst, 8'h0D);
            push_b(inst, 8'h0A);
        end
    endtask

    // Holds req for exactly one sampling edge; returns just after that edge.
    task automatic start(input bit inst, input logic [1:0] t, input logic [31:0] d);
        type_tx = t;
        dat_tx  = d;
        if (inst) req1 = 1'b1;
        else      req0 = 1'b1;
        tick();
        req1 = 1'b0;
        req0 = 1'b0;
    endtask

    // Number of further edges until ack is seen; -1 when the budget runs out.
    task automatic wait_ack(input bit inst, input int budget, output int k);
        k = 0;
        while (k < budget && !((inst ? ack1 : ack0) === 1'b1)) begin
            tick();
            k++;
        end
        if (k >= budget) k = -1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        nchk++;
        if ({busy1, ack1, vld1, d1} !== 11'h0) begin
            nerr++;
            $display("FAIL reset_crlf1: got busy/ack/vld/d=%b/%b/%b/%h, expected 0/0/0/00", busy1, ack1, vld1, d1);
        end
        nchk++;
        if ({busy0, ack0, vld0, d0} !== 11'h0) begin
            nerr++;
            $display("FAIL reset_crlf0: got busy/ack/vld/d=%b/%b/%b/%h, expected 0/0/0/00", busy0, ack0, vld0, d0);
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_word();
        int k;
        push_frame(1'b1, T_HEXW, 32'h12AB34CD, 1'b1);
        start(1'b1, T_HEXW, 32'h12AB34CD);
        nchk++;
        if (vld1 !== 1'b1) begin
            nerr++;
            $display("FAIL word_first_vld: got vld_tx=%b, expected 1", vld1);
        end
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 10) begin
            nerr++;
            $display("FAIL word_ack_latency: got %0d edges, expected 10", k);
        end
        tick();
        nchk++;
        if ({ack1, busy1} !== 2'b00) begin
            nerr++;
            $display("FAIL word_ack_pulse: got ack/busy=%b/%b, expected 0/0", ack1, busy1);
        end
    endtask

    task automatic test_hexbyte();
        int k, a;
        a = ack_cnt1;
        push_frame(1'b1, T_HEXB, 32'hFFFF_FF0F, 1'b1);
        start(1'b1, T_HEXB, 32'hFFFF_FF0F);
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 4) begin
            nerr++;
            $display("FAIL hexbyte_ack_latency: got %0d edges, expected 4", k);
        end
        repeat (4) tick();
        nchk++;
        if (ack_cnt1 - a != 1) begin
            nerr++;
            $display("FAIL hexbyte_ack_count: got %0d acks, expected 1", ack_cnt1 - a);
        end
    endtask

    task automatic test_raw();
        int k;
        push_frame(1'b1, T_RAW, 32'hFFFF_FF41, 1'b1);
        start(1'b1, T_RAW, 32'hFFFF_FF41);
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 1) begin
            nerr++;
            $display("FAIL raw_ack_latency: got %0d edges, expected 1", k);
        end
        tick();
        push_frame(1'b0, T_HEXW, 32'h12AB34CD, 1'b0);
        start(1'b0, T_HEXW, 32'h12AB34CD);
        wait_ack(1'b0, 40, k);
        nchk++;
        if (k != 8) begin
            nerr++;
            $display("FAIL nocrlf_word_latency: got %0d edges, expected 8", k);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int k;
        logic [7:0] held;
        push_frame(1'b1, T_HEXW, 32'h12AB34CD, 1'b1);
        start(1'b1, T_HEXW, 32'h12AB34CD);
        tick();
        tick();
        rdy  = 1'b0;
        held = d1;
        for (int i = 0; i < 5; i++) begin
            tick();
            nchk++;
            if (d1 !== held || vld1 !== 1'b1) begin
                nerr++;
                $display("FAIL stall_hold: cycle %0d got d_tx=%h vld=%b, expected %h 1", i, d1, vld1, held);
            end
        end
        rdy = 1'b1;
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 8) begin
            nerr++;
            $display("FAIL stall_ack_latency: got %0d edges, expected 8", k);
        end
        tick();
    endtask

    task automatic test_busy_req();
        int k, a;
        a = ack_cnt1;
        push_frame(1'b1, T_HEXW, 32'h0F1E2D3C, 1'b1);
        start(1'b1, T_HEXW, 32'h0F1E2D3C);
        repeat (3) tick();
        type_tx = T_RAW;
        dat_tx  = 32'h0000_0055;
        req1    = 1'b1;
        tick();
        req1    = 1'b0;
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 6) begin
            nerr++;
            $display("FAIL busy_req_latency: got %0d edges, expected 6", k);
        end
        repeat (15) tick();
        nchk++;
        if (busy1 !== 1'b0 || ack_cnt1 - a != 1) begin
            nerr++;
            $display("FAIL busy_req_ignored: got busy=%b acks=%0d, expected 0 and 1", busy1, ack_cnt1 - a);
        end
        push_frame(1'b0, T_CRLF, 32'h0, 1'b0);
        start(1'b0, T_CRLF, 32'hFFFF_FFFF);
        wait_ack(1'b0, 40, k);
        nchk++;
        if (k != 2) begin
            nerr++;
            $display("FAIL crlf_only_latency: got %0d edges, expected 2", k);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int k, a;
        a = ack_cnt1;
        push_frame(1'b1, T_HEXW, 32'hDEADBEEF, 1'b1);
        start(1'b1, T_HEXW, 32'hDEADBEEF);
        repeat (4) tick();
        rstn = 1'b0;
        #1;
        nchk++;
        if (vld1 !== 1'b0 || busy1 !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_abort: got vld=%b busy=%b, expected 0 0", vld1, busy1);
        end
        q1.delete();
        tick();
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        nchk++;
        if (ack_cnt1 != a) begin
            nerr++;
            $display("FAIL midreset_no_ack: got %0d acks, expected 0", ack_cnt1 - a);
        end
        push_frame(1'b1, T_RAW, 32'h0000_005A, 1'b1);
        start(1'b1, T_RAW, 32'h0000_005A);
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 1) begin
            nerr++;
            $display("FAIL midreset_restart: got %0d edges, expected 1", k);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int k;
        push_frame(1'b1, T_HEXB, 32'h0000_003C, 1'b1);
        push_frame(1'b1, T_HEXB, 32'h0000_00A5, 1'b1);
        start(1'b1, T_HEXB, 32'h0000_003C);
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 4) begin
            nerr++;
            $display("FAIL b2b_first: got %0d edges, expected 4", k);
        end
        tick();
        start(1'b1, T_HEXB, 32'h0000_00A5);
        nchk++;
        if (vld1 !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_second_vld: got vld_tx=%b, expected 1", vld1);
        end
        wait_ack(1'b1, 40, k);
        nchk++;
        if (k != 4) begin
            nerr++;
            $display("FAIL b2b_second: got %0d edges, expected 4", k);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_word();
        test_hexbyte();
        test_raw();
        test_backpressure();
        test_busy_req();
        test_reset_mid();
        test_back_to_back();
        nchk++;
        if (q1.size() != 0 || q0.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: got %0d/%0d chars left, expected 0/0", q1.size(), q0.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
